prbs31_checker: RTL and testbench

//   Serial PRBS31 (x^31 + x^28 + 1) checker.

---
 rtl/prbs31_checker.sv | 131 +++++++++++++
 tb/tb_prbs31_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker.sv
// Serial PRBS31 (x^31 + x^28 + 1) checker: self-synchronising acquisition, lock
// qualification, flywheel error counting and density-based loss of lock.
module prbs31_checker #(
    parameter int LOCK_MATCHES = 64,
    parameter int LOSS_WINDOW  = 128,
    parameter int LOSS_THRESH  = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int WW = $clog2(LOSS_WINDOW);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        ACQ    = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10,
        BAD    = 2'b11
    } state_t;

    state_t        st;
    logic [30:0]   sr;
    logic [4:0]    fill;
    logic [MW-1:0] match;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;

    logic          pred;
    logic          bit_err;
    logic          count_err;
    logic          lose;
    logic [EW-1:0] win_err_nx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign state      = st;
    assign pred       = sr[27] ^ sr[30];
    assign bit_err    = in_bit ^ pred;
    assign count_err  = in_valid && (st == LOCKED) && bit_err;
    assign win_err_nx = win_err + EW'(bit_err);
    assign lose       = bit_err && (win_err_nx == EW'(LOSS_THRESH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ACQ;
            sr        <= '0;
            fill      <= '0;
            match     <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= count_err;

            if (clr)
                err_count <= '0;
            else if (count_err)
                err_count <= sat_inc(err_count);

            if (st == BAD) begin
                st      <= ACQ;
                locked  <= 1'b0;
                fill    <= '0;
                match   <= '0;
                win_cnt <= '0;
                win_err <= '0;
            end else if (in_valid) begin
                // Once locked the register flywheels on its own prediction so a line
                // error corrupts only one comparison instead of three.
                sr <= {sr[29:0], (st == LOCKED) ? pred : in_bit};
                case (st)
                    ACQ: begin
                        if (fill == 5'd30) begin
                            fill  <= '0;
                            match <= '0;
                            st    <= VERIFY;
                        end else begin
                            fill <= fill + 1'b1;
                        end
                    end
                    VERIFY: begin
                        if (!bit_err && (sr != '0)) begin
                            if (match == MW'(LOCK_MATCHES - 1)) begin
                                st      <= LOCKED;
                                locked  <= 1'b1;
                                match   <= '0;
                                win_cnt <= '0;
                                win_err <= '0;
                            end else begin
                                match <= match + 1'b1;
                            end
                        end else begin
                            match <= '0;
                        end
                    end
                    default: begin
                        if (lose) begin
                            st      <= ACQ;
                            locked  <= 1'b0;
                            fill    <= '0;
                            match   <= '0;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else if (win_cnt == WW'(LOSS_WINDOW - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= win_err_nx;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: directed table, corner sequences and random stimulus
// compared every cycle against a behavioural model of the checker.
module tb_prbs31_checker;

    localparam int LOCK_MATCHES = 64;
    localparam int LOSS_WINDOW  = 128;
    localparam int LOSS_THRESH  = 16;
    localparam int CMAX         = 65535;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_bit;
    logic        locked, err_pulse;
    logic [1:0]  state;
    logic [15:0] err_count;
    logic        locked6, err_pulse6;
    logic [1:0]  state6;
    logic [3:0]  err_count6;

    int checks = 0;
    int errors = 0;

    prbs31_checker dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
        .locked(locked), .state(state), .err_pulse(err_pulse), .err_count(err_count)
    );

    prbs31_checker #(.CNT_W(4), .LOSS_WINDOW(128), .LOSS_THRESH(128)) dut6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
        .locked(locked6), .state(state6), .err_pulse(err_pulse6), .err_count(err_count6)
    );

    always #5 clk = ~clk;

    // Transmitted sequence: seed 31'd1 sent MSB first, then b[n] = b[n-28] ^ b[n-31].
    bit gs[$];

    function automatic bit gen_next();
        int n;
        bit b;
        n = gs.size();
        if (n < 31) b = (n == 30);
        else        b = gs[n-28] ^ gs[n-31];
        gs.push_back(b);
        return b;
    endfunction

    // Behavioural model: reference history of the last 31 decided bits (newest at back).
    bit m_ref[$];
    int m_state, m_fill, m_match, m_win, m_werr, m_cnt;
    bit m_pulse;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_cnt = 0; m_pulse = 0;
        m_ref.delete();
        for (int i = 0; i < 31; i++) m_ref.push_back(1'b0);
        gs.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_bit = 1'b0; clr = 1'b0; rst_n = 1'b0;
        #1;
        chk("reset", {locked, state, err_pulse, err_count}, 64'd0);
        chk("reset6", {locked6, state6, err_pulse6, err_count6}, 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: v=valid, flip=invert the line bit, c=clr, zero=drive constant 0.
    task automatic step(input bit v, input bit flip, input bit c, input bit zero);
        bit b, pred, nz;
        if (v) b = zero ? 1'b0 : (gen_next() ^ flip);
        else   b = 1'($urandom_range(0, 1));
        in_valid = v; in_bit = b; clr = c;
        @(posedge clk);
        m_pulse = 1'b0;
        if (v) begin
            pred = m_ref[3] ^ m_ref[0];
            if (m_state == 0) begin
                m_ref.push_back(b);
                m_fill++;
                if (m_fill == 31) begin m_state = 1; m_fill = 0; m_match = 0; end
            end else if (m_state == 1) begin
                nz = 1'b0;
                foreach (m_ref[i]) nz |= m_ref[i];
                if (b == pred && nz) begin
                    m_match++;
                    if (m_match == LOCK_MATCHES) begin
                        m_state = 2; m_match = 0; m_win = 0; m_werr = 0;
                    end
                end else begin
                    m_match = 0;
                end
                m_ref.push_back(b);
            end else begin
                m_ref.push_back(pred);
                if (b != pred) begin
                    m_pulse = 1'b1;
                    if (m_cnt < CMAX) m_cnt++;
                    m_werr++;
                end
                if (m_werr == LOSS_THRESH) begin
                    m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
                end else begin
                    m_win++;
                    if (m_win == LOSS_WINDOW) begin m_win = 0; m_werr = 0; end
                end
            end
            void'(m_ref.pop_front());
        end
        if (c) m_cnt = 0;
        #1 chk("cycle", {locked, state, err_pulse, err_count},
               {(m_state == 2), 2'(m_state), m_pulse, 16'(m_cnt)});
    endtask

    typedef struct {
        int         n_clean;
        bit         flip;
        bit         exp_lk;
        logic [1:0] exp_st;
        bit         exp_pulse;
        int         exp_cnt;
    } row_t;

    row_t tbl[$];

    initial begin
        // n_clean clean valid bits, then one inverted bit if flip; expectations after the row.
        tbl.push_back('{94,    1'b0, 1'b0, 2'b01, 1'b0, 0});
        tbl.push_back('{1,     1'b0, 1'b1, 2'b10, 1'b0, 0});
        tbl.push_back('{10000, 1'b0, 1'b1, 2'b10, 1'b0, 0});
        tbl.push_back('{199,   1'b1, 1'b1, 2'b10, 1'b1, 1});
        tbl.push_back('{40,    1'b0, 1'b1, 2'b10, 1'b0, 1});
        for (int k = 2; k <= 16; k++) tbl.push_back('{2, 1'b1, 1'b1, 2'b10, 1'b1, k});
        tbl.push_back('{2,     1'b1, 1'b0, 2'b00, 1'b1, 17});
        tbl.push_back('{94,    1'b0, 1'b0, 2'b01, 1'b0, 17});
        tbl.push_back('{1,     1'b0, 1'b1, 2'b10, 1'b0, 17});

        do_reset();
        foreach (tbl[r]) begin
            for (int i = 0; i < tbl[r].n_clean; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
            if (tbl[r].flip) step(1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("row%0d", r), {locked, state, err_pulse, err_count},
                {tbl[r].exp_lk, tbl[r].exp_st, tbl[r].exp_pulse, 16'(tbl[r].exp_cnt)});
        end

        // clr coincident with an error clears the count but the pulse still fires
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_err", {err_pulse, err_count, locked}, {1'b1, 16'd0, 1'b1});
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr_after", {err_pulse, err_count}, {1'b0, 16'd0});

        // narrow counter saturation with loss of lock disabled, then async reset mid-lock
        do_reset();
        for (int i = 0; i < 95; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lock6", {locked6, state6}, {1'b1, 2'b10});
        for (int e = 0; e < 20; e++) begin
            for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("sat6", {locked6, state6, err_count6}, {1'b1, 2'b10, 4'hf});
        chk("cnt20", {locked, err_count}, {1'b1, 16'd20});
        #2 rst_n = 1'b0;
        #1;
        chk("async6", {locked6, err_count6}, {1'b0, 4'h0});
        chk("async", {locked, err_count, state}, {1'b0, 16'd0, 2'b00});

        // stuck-at-0 line never qualifies lock
        do_reset();
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("stuck0", {locked, state}, {1'b0, 2'b01});

        // 50% valid duty: lock exactly at the 95th valid bit
        do_reset();
        begin
            int nv = 0;
            int cyc = 0;
            while (nv < 95 && cyc < 2000) begin
                bit v;
                v = 1'($urandom_range(0, 1));
                step(v, 1'b0, 1'b0, 1'b0);
                cyc++;
                if (v) begin
                    nv++;
                    if (nv == 94) chk("prelock94", locked, 1'b0);
                end
            end
            chk("lock95", {locked, err_count}, {1'b1, 16'd0});
        end

        // random valid, sparse line errors and clears against the model
        do_reset();
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 499) == 0), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
